// File: rtl/pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_pkg : shared types and constants for pipeline-stage registers   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package pipe_pkg;

  localparam int PIPE_W = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_t;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/dffe_w.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dffe_w : WIDTH-bit enabled register, async reset, sync clear         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module dffe_w import pipe_pkg::*; #(
  parameter int               WIDTH   = PIPE_W,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  // Clear beats enable so a flush always wins over a coincident load.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)    r_q <= RST_VAL;
    else if (clr) r_q <= RST_VAL;
    else if (en)  r_q <= d;
  end

  assign q = r_q;

endmodule : dffe_w
`default_nettype wire

// File: rtl/pipe_reg_skid.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_reg_skid : valid/ready pipeline register, optional 2-entry skid |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pipe_reg_skid import pipe_pkg::*; #(
  parameter int               WIDTH   = PIPE_W,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter int               SKID    = 1
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occ
);

  pipe_state_t      r_state;
  pipe_state_t      w_state_nxt;
  logic             w_accept;
  logic             w_fire;
  logic             w_load_main;
  logic             w_main_from_skid;
  logic             w_load_skid;
  logic [WIDTH-1:0] w_main_d;
  logic [WIDTH-1:0] w_main_q;
  logic [WIDTH-1:0] w_skid_q;

  assign w_accept = in_valid & in_ready;
  assign w_fire   = out_valid & out_ready;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) r_state <= EMPTY;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_load_main      = 1'b0;
    w_main_from_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (flush) begin
      w_state_nxt = EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            w_load_main = 1'b1;
            w_state_nxt = ONE;
          end
        end
        ONE: begin
          if (w_accept && w_fire) begin
            w_load_main = 1'b1;
          end else if (w_accept) begin
            // Only reachable with a skid entry; without one in_ready implies fire.
            if (SKID != 0) begin
              w_load_skid = 1'b1;
              w_state_nxt = TWO;
            end
          end else if (w_fire) begin
            w_state_nxt = EMPTY;
          end
        end
        TWO: begin
          if (w_fire) begin
            w_load_main      = 1'b1;
            w_main_from_skid = 1'b1;
            w_state_nxt      = ONE;
          end
        end
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

  assign w_main_d = w_main_from_skid ? w_skid_q : in_data;

  dffe_w #(
    .WIDTH   (WIDTH),
    .RST_VAL (RST_VAL)
  ) u_main (
    .clk  (clk),
    .clrn (clrn),
    .en   (w_load_main),
    .clr  (flush),
    .d    (w_main_d),
    .q    (w_main_q)
  );

  generate
    if (SKID != 0) begin : g_skid
      dffe_w #(
        .WIDTH   (WIDTH),
        .RST_VAL (RST_VAL)
      ) u_skid (
        .clk  (clk),
        .clrn (clrn),
        .en   (w_load_skid),
        .clr  (flush),
        .d    (in_data),
        .q    (w_skid_q)
      );
      assign in_ready = (r_state == EMPTY) || (r_state == ONE);
    end else begin : g_no_skid
      logic w_unused_skid;
      assign w_unused_skid = w_load_skid;
      assign w_skid_q      = RST_VAL;
      assign in_ready      = !out_valid || out_ready;
    end
  endgenerate

  assign out_valid = (r_state == ONE) || (r_state == TWO);
  assign out_data  = w_main_q;

  always_comb begin
    occ = 2'd0;
    case (r_state)
      ONE:     occ = 2'd1;
      TWO:     occ = 2'd2;
      default: occ = 2'd0;
    endcase
  end

endmodule : pipe_reg_skid
`default_nettype wire

// File: tb/tb_pipe_reg_skid.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pipe_reg_skid : directed and scoreboarded bench, SKID=1 and SKID=0 |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_pipe_reg_skid;

  logic clk  = 1'b0;
  logic clrn = 1'b1;

  // dut1: SKID=1, 32 bits, RST_VAL=DEADBEEF
  logic        flush1 = 1'b0, in_valid1 = 1'b0, out_ready1 = 1'b0;
  logic [31:0] in_data1 = '0;
  logic        in_ready1, out_valid1;
  logic [31:0] out_data1;
  logic [1:0]  occ1;

  // dut0: SKID=0, 8 bits, RST_VAL=0
  logic        flush0 = 1'b0, in_valid0 = 1'b0, out_ready0 = 1'b0;
  logic [7:0]  in_data0 = '0;
  logic        in_ready0, out_valid0;
  logic [7:0]  out_data0;
  logic [1:0]  occ0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipe_reg_skid #(.WIDTH(32), .RST_VAL(32'hDEADBEEF), .SKID(1)) u_dut1 (
    .clk(clk), .clrn(clrn), .flush(flush1),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
    .occ(occ1)
  );

  pipe_reg_skid #(.WIDTH(8), .RST_VAL(8'h00), .SKID(0)) u_dut0 (
    .clk(clk), .clrn(clrn), .flush(flush0),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
    .occ(occ0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] q1[$];
  logic [7:0]  q0[$];
  logic        pv1, pr1, pa1, pf1, pv0, pr0, pa0, pf0;
  logic [31:0] pd1, pi1;
  logic [7:0]  pd0, pi0;

  initial begin
    // ---------------- reset state ----------------
    #1 clrn = 1'b0;
    #2;
    chk("rst_out_valid1", out_valid1, 0);
    chk("rst_in_ready1",  in_ready1,  1);
    chk("rst_occ1",       occ1,       0);
    chk("rst_out_data1",  out_data1,  32'hDEADBEEF);
    chk("rst_out_valid0", out_valid0, 0);
    chk("rst_in_ready0",  in_ready0,  1);
    chk("rst_out_data0",  out_data0,  0);
    #9 clrn = 1'b1;
    tick();

    // ---------------- streaming 1..100 ----------------
    in_valid1  = 1'b1;
    out_ready1 = 1'b1;
    in_data1   = 32'd1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      chk("stream_valid", out_valid1, 1);
      chk("stream_data",  out_data1,  i);
      chk("stream_ready", in_ready1,  1);
      in_data1 = i + 1;
    end
    in_valid1 = 1'b0;
    tick();
    chk("stream_drain_valid", out_valid1, 0);
    chk("stream_drain_occ",   occ1,       0);

    // ---------------- backpressure into skid ----------------
    out_ready1 = 1'b0;
    in_valid1  = 1'b1;
    in_data1   = 32'hA1;
    tick();
    chk("bp_one_occ",  occ1,      1);
    chk("bp_one_data", out_data1, 32'hA1);
    in_data1 = 32'hA2;
    tick();
    chk("bp_two_occ",   occ1,      2);
    chk("bp_two_ready", in_ready1, 0);
    chk("bp_two_data",  out_data1, 32'hA1);
    in_data1 = 32'hBAD;
    tick();
    chk("bp_hold_data", out_data1, 32'hA1);
    chk("bp_hold_occ",  occ1,      2);
    out_ready1 = 1'b1;
    tick();
    chk("bp_fire1_data",  out_data1, 32'hA2);
    chk("bp_fire1_occ",   occ1,      1);
    chk("bp_fire1_ready", in_ready1, 1);
    in_valid1 = 1'b0;
    tick();
    chk("bp_fire2_valid", out_valid1, 0);
    chk("bp_fire2_occ",   occ1,       0);

    // ---------------- flush collision ----------------
    out_ready1 = 1'b0;
    in_valid1  = 1'b1;
    in_data1   = 32'h55;
    tick();
    chk("fl_pre_data", out_data1, 32'h55);
    flush1     = 1'b1;
    in_data1   = 32'h66;
    out_ready1 = 1'b1;
    tick();
    flush1    = 1'b0;
    in_valid1 = 1'b0;
    chk("fl_valid", out_valid1, 0);
    chk("fl_occ",   occ1,       0);
    chk("fl_data",  out_data1,  32'hDEADBEEF);
    chk("fl_ready", in_ready1,  1);
    tick();
    chk("fl_after_valid", out_valid1, 0);
    chk("fl_after_data",  out_data1,  32'hDEADBEEF);

    // ---------------- async reset mid-stream from TWO ----------------
    out_ready1 = 1'b0;
    in_valid1  = 1'b1;
    in_data1   = 32'hB1;
    tick();
    in_data1 = 32'hB2;
    tick();
    in_valid1 = 1'b0;
    chk("mr_pre_occ", occ1, 2);
    clrn = 1'b0;
    #2;
    chk("mr_valid", out_valid1, 0);
    chk("mr_data",  out_data1,  32'hDEADBEEF);
    chk("mr_ready", in_ready1,  1);
    chk("mr_occ",   occ1,       0);
    #2 clrn = 1'b1;
    tick();
    chk("mr_after_valid", out_valid1, 0);

    // ---------------- SKID=0, toggling out_ready ----------------
    in_valid0  = 1'b1;
    in_data0   = 8'h10;
    out_ready0 = 1'b1;
    #1 chk("s0_empty_ready", in_ready0, 1);
    tick();
    chk("s0_d10", out_data0, 8'h10);
    chk("s0_v10", out_valid0, 1);
    in_data0   = 8'h11;
    out_ready0 = 1'b0;
    #1 chk("s0_full_ready_lo", in_ready0, 0);
    tick();
    chk("s0_hold10", out_data0, 8'h10);
    out_ready0 = 1'b1;
    #1 chk("s0_full_ready_hi", in_ready0, 1);
    tick();
    chk("s0_d11", out_data0, 8'h11);
    in_data0   = 8'h12;
    out_ready0 = 1'b0;
    #1 chk("s0_full_ready_lo2", in_ready0, 0);
    tick();
    chk("s0_hold11", out_data0, 8'h11);
    out_ready0 = 1'b1;
    #1 chk("s0_full_ready_hi2", in_ready0, 1);
    tick();
    chk("s0_d12", out_data0, 8'h12);
    chk("s0_occ", occ0, 1);
    in_valid0 = 1'b0;
    tick();
    chk("s0_drain_valid", out_valid0, 0);
    out_ready0 = 1'b0;
    #1 chk("s0_empty_ready2", in_ready0, 1);

    // ---------------- random valid/ready with scoreboards ----------------
    for (int n = 0; n < 10000; n++) begin
      in_valid1  = ($urandom_range(0, 3) != 0);
      in_data1   = $urandom;
      out_ready1 = ($urandom_range(0, 2) != 0);
      flush1     = ($urandom_range(0, 63) == 0);
      in_valid0  = ($urandom_range(0, 3) != 0);
      in_data0   = 8'($urandom);
      out_ready0 = ($urandom_range(0, 2) != 0);
      flush0     = ($urandom_range(0, 63) == 0);
      #1;
      pv1 = out_valid1; pr1 = out_ready1; pd1 = out_data1;
      pa1 = in_valid1 & in_ready1; pi1 = in_data1; pf1 = flush1;
      pv0 = out_valid0; pr0 = out_ready0; pd0 = out_data0;
      pa0 = in_valid0 & in_ready0; pi0 = in_data0; pf0 = flush0;
      tick();
      if (pf1) begin
        q1.delete();
      end else begin
        if (pv1 && pr1) begin
          if (q1.size() == 0) chk("rnd1_fire_empty", pv1, 0);
          else begin
            chk("rnd1_data", pd1, q1[0]);
            void'(q1.pop_front());
          end
        end else if (pv1) begin
          chk("rnd1_stall_valid", out_valid1, 1);
          chk("rnd1_stall_data",  out_data1,  pd1);
        end
        if (pa1) q1.push_back(pi1);
      end
      chk("rnd1_occ", occ1, q1.size());
      if (pf0) begin
        q0.delete();
      end else begin
        if (pv0 && pr0) begin
          if (q0.size() == 0) chk("rnd0_fire_empty", pv0, 0);
          else begin
            chk("rnd0_data", pd0, q0[0]);
            void'(q0.pop_front());
          end
        end else if (pv0) begin
          chk("rnd0_stall_valid", out_valid0, 1);
          chk("rnd0_stall_data",  out_data0,  pd0);
        end
        if (pa0) q0.push_back(pi0);
      end
      chk("rnd0_occ", occ0, q0.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_pipe_reg_skid
`default_nettype wire
